// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - RV32I load/store unit driving a word-wide SPRAM responder
// Sub-word stores are done as read-modify-write because the memory only writes full words.
module data_mem_lsu #(
    parameter int ADDR_WORD_BITS = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE, RD, RD_CAP, RMW_RD, RMW_MRG, WR, RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  byte_off_q, byte_off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic        mem_memwrite_q, mem_memwrite_d;
    logic        mem_memread_q, mem_memread_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        funct3_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        req_bad;

    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old_w,
                                                input logic [31:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] mask;
        logic [31:0] data;
        if (f3[1:0] == 2'b00) begin
            mask = 32'h0000_00ff << {off, 3'b000};
            data = {24'h0, wd[7:0]} << {off, 3'b000};
        end else begin
            mask = off[1] ? 32'hffff_0000 : 32'h0000_ffff;
            data = off[1] ? {wd[15:0], 16'h0} : {16'h0, wd[15:0]};
        end
        return (old_w & ~mask) | (data & mask);
    endfunction

    always_comb begin
        if (req_write) begin
            funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010)
                     || (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                    || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr[31:ADDR_WORD_BITS+2] != '0);
        req_bad      = !funct3_ok || misaligned || out_of_range;
    end

    always_comb begin
        state_d          = state_q;
        funct3_d         = funct3_q;
        byte_off_d       = byte_off_q;
        wdata_d          = wdata_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        mem_memwrite_d   = 1'b0;
        mem_memread_d    = 1'b0;
        resp_valid_d     = 1'b0;
        resp_err_d       = 1'b0;
        resp_rdata_d     = 32'h0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d   = req_funct3;
                    byte_off_d = req_addr[1:0];
                    wdata_d    = req_wdata;
                    if (req_bad) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        state_d      = RESP;
                    end else begin
                        mem_addr_d = {{(32-ADDR_WORD_BITS){1'b0}}, req_addr[ADDR_WORD_BITS+1:2]};
                        if (!req_write) begin
                            mem_memread_d = 1'b1;
                            state_d       = RD;
                        end else if (req_funct3 == 3'b010) begin
                            mem_memwrite_d   = 1'b1;
                            mem_write_data_d = req_wdata;
                            state_d          = WR;
                        end else begin
                            mem_memread_d = 1'b1;
                            state_d       = RMW_RD;
                        end
                    end
                end
            end
            RD:      state_d = RD_CAP;
            RD_CAP: begin
                resp_rdata_d = load_extract(mem_read_data, funct3_q, byte_off_q);
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RMW_RD:  state_d = RMW_MRG;
            RMW_MRG: begin
                mem_write_data_d = store_merge(mem_read_data, wdata_q, funct3_q, byte_off_q);
                mem_memwrite_d   = 1'b1;
                state_d          = WR;
            end
            WR: begin
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            funct3_q         <= 3'b000;
            byte_off_q       <= 2'b00;
            wdata_q          <= 32'h0;
            mem_addr_q       <= 32'h0;
            mem_write_data_q <= 32'h0;
            mem_memwrite_q   <= 1'b0;
            mem_memread_q    <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= 32'h0;
        end else begin
            state_q          <= state_d;
            funct3_q         <= funct3_d;
            byte_off_q       <= byte_off_d;
            wdata_q          <= wdata_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            mem_memwrite_q   <= mem_memwrite_d;
            mem_memread_q    <= mem_memread_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
        end
    end

    assign req_ready      = (state_q == IDLE) && rst_n;
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_memwrite   = mem_memwrite_q;
    assign mem_memread    = mem_memread_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - directed self-checking bench for data_mem_lsu
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_read_data;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:255];

    int          op_lat;
    logic [31:0] op_rdata;
    logic        op_err;
    int          op_reads;
    int          op_writes;
    int          op_overlap;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        op_ready_after;

    logic        mon_en = 1'b0;
    int          mon_acc;
    int          mon_resp;
    int          mon_bad_order;
    logic [31:0] mon_first_rdata;

    data_mem_lsu #(.ADDR_WORD_BITS(14)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_memwrite) mem[mem_addr[7:0]] <= mem_write_data;
        if (mem_memread)  mem_read_data <= mem[mem_addr[7:0]];
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (req_valid && req_ready) mon_acc = mon_acc + 1;
            if (resp_valid) begin
                if (mon_resp == 0) mon_first_rdata = resp_rdata;
                mon_resp = mon_resp + 1;
            end
            if (mon_acc - mon_resp > 1 || mon_resp > mon_acc) mon_bad_order = mon_bad_order + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        bit seen;
        @(negedge clk);
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        op_lat = -1; op_reads = 0; op_writes = 0; op_overlap = 0;
        op_addr = 32'hffff_ffff; op_wdata = 32'h0; op_rdata = 32'h0; op_err = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (mem_memread && mem_memwrite) op_overlap++;
            if (mem_memread)  begin op_reads++;  op_addr = mem_addr; end
            if (mem_memwrite) begin op_writes++; op_addr = mem_addr; op_wdata = mem_write_data; end
            if (resp_valid) begin
                op_lat = k; op_rdata = resp_rdata; op_err = resp_err; seen = 1'b1;
            end
        end
        @(negedge clk);
        op_ready_after = req_ready;
        if (mem_memread || mem_memwrite || resp_valid) op_overlap++;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] exp);
        run_op(1'b0, f3, addr, 32'h0);
        check({tag, "_rdata"}, op_rdata, exp);
        check({tag, "_lat"}, op_lat, 2);
        check({tag, "_reads"}, op_reads, 1);
        check({tag, "_writes"}, op_writes, 0);
        check({tag, "_addr"}, op_addr, {2'b00, addr[31:2]});
        check({tag, "_err"}, {31'h0, op_err}, 0);
    endtask

    task automatic store_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] exp_word, input int lat,
                             input int reads);
        run_op(1'b1, f3, addr, wd);
        check({tag, "_wdata"}, op_wdata, exp_word);
        check({tag, "_lat"}, op_lat, lat);
        check({tag, "_reads"}, op_reads, reads);
        check({tag, "_writes"}, op_writes, 1);
        check({tag, "_addr"}, op_addr, {2'b00, addr[31:2]});
        check({tag, "_overlap"}, op_overlap, 0);
        check({tag, "_rdata0"}, op_rdata, 0);
    endtask

    task automatic err_chk(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr);
        run_op(wr, f3, addr, 32'h1234_5678);
        check({tag, "_err"}, {31'h0, op_err}, 1);
        check({tag, "_rdata"}, op_rdata, 0);
        check({tag, "_lat"}, op_lat, 0);
        check({tag, "_strobes"}, op_reads + op_writes, 0);
        check({tag, "_ready"}, {31'h0, op_ready_after}, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h8081_f2f3;
        mem[8'h12] = 32'ha5a5_a5a5;
        mem_read_data = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 0);
        check("rst_resp_valid", {31'h0, resp_valid}, 0);
        check("rst_strobes", {30'h0, mem_memread, mem_memwrite}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'h0, req_ready}, 1);

        load_chk("lb",  3'b000, 32'h40, 32'hffff_fff3);
        load_chk("lbu", 3'b100, 32'h43, 32'h0000_0080);
        load_chk("lh",  3'b001, 32'h42, 32'hffff_8081);
        load_chk("lhu", 3'b101, 32'h40, 32'h0000_f2f3);

        store_chk("sw", 3'b010, 32'h44, 32'hdead_beef, 32'hdead_beef, 1, 0);
        load_chk("lw", 3'b010, 32'h44, 32'hdead_beef);
        store_chk("sb", 3'b000, 32'h46, 32'h0000_0055, 32'hde55_beef, 3, 1);
        store_chk("sh", 3'b001, 32'h44, 32'h0000_1234, 32'hde55_1234, 3, 1);
        load_chk("lw2", 3'b010, 32'h44, 32'hde55_1234);

        err_chk("e_lw_mis", 1'b0, 3'b010, 32'h42);
        err_chk("e_sh_mis", 1'b1, 3'b001, 32'h41);
        err_chk("e_f3",     1'b0, 3'b011, 32'h40);
        err_chk("e_range",  1'b0, 3'b010, 32'h0001_0000);
        err_chk("e_st_f3",  1'b1, 3'b100, 32'h40);

        // Reset lands one cycle after an SB is accepted.
        @(negedge clk);
        req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h48; req_wdata = 32'h0000_0011;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("abort_read_issued", {31'h0, mem_memread}, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        op_reads = 0; op_writes = 0; op_lat = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            op_reads  += int'(mem_memread);
            op_writes += int'(mem_memwrite);
            op_lat    += int'(resp_valid);
        end
        check("abort_strobes", op_reads + op_writes, 0);
        check("abort_resp", op_lat, 0);
        check("abort_ready", {31'h0, req_ready}, 1);
        load_chk("abort_rb", 3'b010, 32'h48, 32'ha5a5_a5a5);

        mon_acc = 0; mon_resp = 0; mon_bad_order = 0; mon_first_rdata = 32'h0;
        @(negedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int n;
            case (i)
                0: begin req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h44; req_wdata = 32'h0; end
                1: begin req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h4c; req_wdata = 32'h1122_3344; end
                default: begin req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h4d; req_wdata = 32'h0000_00aa; end
            endcase
            req_valid = 1'b1;
            n = 0;
            while (!req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_wait", {31'h0, req_ready}, 1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        check("b2b_accepts", mon_acc, 3);
        check("b2b_resps", mon_resp, 3);
        check("b2b_order", mon_bad_order, 0);
        check("b2b_first", mon_first_rdata, 32'hde55_1234);
        load_chk("b2b_rb", 3'b010, 32'h4c, 32'h1122_aa44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Load/store initiator between the core's memory stage and the SPRAM-backed `data_memory` responder.
- Converts byte-addressed RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide `memread`/`memwrite` strobes.
- Performs lane extraction and sign/zero extension on loads.
- Performs read-modify-write for sub-word stores, because the memory always writes full 32-bit words.
- Rejects misaligned, illegal or out-of-range accesses without touching memory.

Parameters:
ADDR_WORD_BITS, 14, number of word-address bits the memory decodes (2^14 words = 64 KiB)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
req_valid  input  1  core presents a request
req_ready  output  1  LSU can accept; high only in IDLE and when rst_n=1
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 of the load/store
req_addr  input  32  byte address
req_wdata  input  32  store data; valid bytes right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  qualifies resp_valid: misaligned, illegal funct3 or out-of-range
mem_addr  output  32  word address to memory = {zeros, req_addr[ADDR_WORD_BITS+1:2]}
mem_write_data  output  32  full word to memory
mem_memwrite  output  1  write strobe
mem_memread  output  1  read strobe
mem_read_data  input  32  memory data; valid the cycle after a memread cycle, held until the next strobe

Behaviour:
- Reset: on any rising edge with rst_n=0:
  - state goes to IDLE.
  - resp_valid, resp_err, resp_rdata, mem_addr, mem_write_data, mem_memwrite and mem_memread are cleared to 0.
  - Any in-flight operation is abandoned with no response; strobes are low from the following cycle.
- Registered outputs: all outputs are registered except req_ready = (state==IDLE) & rst_n.
- Strobe exclusion: mem_memread and mem_memwrite are never both 1.
- Accept: a handshake occurs at edge E0 when req_valid & req_ready. Address, funct3, data and write are latched at E0.
- Legality checks:
  - Loads: funct3 in {000,001,010,100,101}. Stores: funct3 in {000,001,010}. Anything else is illegal.
  - Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
  - Range: req_addr[31:ADDR_WORD_BITS+2] must be 0.
- States: IDLE, RD, RD_CAP, RMW_RD, RMW_MRG, WR, RESP.
- Error (illegal, misaligned or out-of-range) at E0:
  - IDLE → RESP; resp_valid=1 and resp_err=1 during E0–E1.
  - No strobe is issued.
- Load:
  - IDLE → RD; mem_memread=1 during E0–E1.
  - RD → RD_CAP; mem_read_data becomes valid after E1.
  - RD_CAP → RESP at E2; the extracted result is registered into resp_rdata and resp_valid=1 during E2–E3.
  - RESP → IDLE at E3.
- Load extraction (little-endian, lane 0 = bits 7:0):
  - LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- SW: IDLE → WR.
  - mem_memwrite=1 and mem_write_data=req_wdata during E0–E1.
  - resp_valid=1 during E1–E2; back to IDLE at E2.
- SB/SH (read-modify-write):
  - mem_memread=1 during E0–E1 (RMW_RD).
  - At E2 (RMW_MRG) the stored byte/halfword is merged into mem_read_data at its lane; other lanes are preserved.
  - mem_memwrite=1 with the merged word during E2–E3 (WR).
  - resp_valid during E3–E4; back to IDLE at E4.
- Pulse rules:
  - resp_valid is exactly one cycle per accepted request.
  - Each strobe is exactly one cycle.
  - mem_addr is stable for the whole operation.
- Throughput: no new request is accepted until the state is back in IDLE. req_valid while busy is ignored; the core must hold it.
- Latency summary (accept to resp_valid, in cycles):
  - error: 0 (pulse in the cycle after accept)
  - SW: 1
  - load: 2
  - SB/SH: 3

Test Plan:
- Preload word 0x10 = 0x8081_F2F3. LB addr 0x40 → resp_rdata 0xFFFF_FFF3. LBU addr 0x43 → 0x0000_0080. LH addr 0x42 → 0xFFFF_8081. LHU addr 0x40 → 0x0000_F2F3. Each shows memread for one cycle with mem_addr=0x10 and resp two cycles after accept.
- SW addr 0x44, data 0xDEAD_BEEF → memwrite for one cycle with mem_addr=0x11 and data 0xDEADBEEF; resp_valid one cycle later; a subsequent LW returns 0xDEADBEEF.
- With word 0x11 = 0xDEADBEEF: SB addr 0x46, data 0x0000_0055 → memread, then merged write 0xDE55BEEF; SH addr 0x44, data 0x1234 → write 0xDE551234. No memread/memwrite overlap.
- LW addr 0x42, SH addr 0x41, funct3=011 load, and addr 0x0001_0000 (ADDR_WORD_BITS=14) → each gives resp_err=1 with resp_rdata=0, zero memory strobes, and req_ready high again the next cycle.
- Assert rst_n=0 in the cycle after accepting an SB → strobes low from the next cycle, no resp_valid, state IDLE; the memory word is unchanged when read back.
- Hold req_valid high continuously for back-to-back LW/SW/SB → exactly one accept per return to IDLE and one resp_valid per accept, in order.
